// File: rtl/stack_pkg.sv
// Shared constants for the stack micro-sequencer: opcodes, FSM encoding,
// response error codes and the operand precondition check.
package stack_pkg;

    // Instruction opcodes
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_DUP  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    // Sequencer FSM encoding
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StPopA  = 3'd1;
    localparam logic [2:0] StCapA  = 3'd2;
    localparam logic [2:0] StPopB  = 3'd3;
    localparam logic [2:0] StCapB  = 3'd4;
    localparam logic [2:0] StPush1 = 3'd5;
    localparam logic [2:0] StPush2 = 3'd6;
    localparam logic [2:0] StDone  = 3'd7;

    // Response error codes
    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_REJECT = 1'b1;

    // True when the stack holds enough operands / free slots for the opcode.
    function automatic logic op_allowed(logic [2:0] op, int unsigned lvl, int unsigned depth);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_NOP:                ok = 1'b1;
            OP_PUSH:               ok = (lvl < depth);
            OP_POP:                ok = (lvl >= 1);
            OP_ADD, OP_SUB, OP_SWAP: ok = (lvl >= 2);
            OP_DUP:                ok = (lvl >= 1) && (lvl < depth);
            default:               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/stack_op_sequencer.sv
// Micro-sequencer that executes one stack-machine instruction at a time by
// strobing push/pop on an external stack, then returns a held response.
module stack_op_sequencer
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             st_push,
    output logic             st_pop,
    output logic [WIDTH-1:0] st_data_in,
    input  logic [WIDTH-1:0] st_data_out,
    output logic [LVL_W-1:0] level
);

    logic [2:0]       state_q, state_d;
    logic [2:0]       opc_q, opc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rerr_q, rerr_d;
    logic [WIDTH-1:0] alu;

    // b comes straight off st_data_out in CAP_B, so the ALU uses it directly.
    always_comb begin
        alu = (opc_q == OP_SUB) ? (st_data_out - a_q) : (st_data_out + a_q);
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        a_d     = a_q;
        b_d     = b_q;
        level_d = level_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        case (state_q)
            StIdle: begin
                if (op_valid) begin
                    opc_d   = op_code;
                    rdata_d = '0;
                    if (!op_allowed(op_code, 32'(level_q), DEPTH)) begin
                        rerr_d  = ERR_REJECT;
                        state_d = StDone;
                    end else begin
                        rerr_d = ERR_NONE;
                        case (op_code)
                            OP_NOP:  state_d = StDone;
                            OP_PUSH: begin
                                din_d   = op_imm;
                                state_d = StPush1;
                            end
                            default: state_d = StPopA;
                        endcase
                    end
                end
            end
            StPopA: begin
                level_d = level_q - LVL_W'(1);
                state_d = StCapA;
            end
            StCapA: begin
                a_d = st_data_out;
                case (opc_q)
                    OP_POP: begin
                        rdata_d = st_data_out;
                        state_d = StDone;
                    end
                    OP_DUP: begin
                        din_d   = st_data_out;
                        state_d = StPush1;
                    end
                    default: state_d = StPopB;
                endcase
            end
            StPopB: begin
                level_d = level_q - LVL_W'(1);
                state_d = StCapB;
            end
            StCapB: begin
                b_d     = st_data_out;
                din_d   = (opc_q == OP_SWAP) ? a_q : alu;
                state_d = StPush1;
            end
            StPush1: begin
                level_d = level_q + LVL_W'(1);
                if (opc_q == OP_DUP || opc_q == OP_SWAP) begin
                    din_d   = (opc_q == OP_SWAP) ? b_q : a_q;
                    state_d = StPush2;
                end else begin
                    // The value just pushed is the response for PUSH/ADD/SUB.
                    rdata_d = din_q;
                    state_d = StDone;
                end
            end
            StPush2: begin
                level_d = level_q + LVL_W'(1);
                rdata_d = din_q;
                state_d = StDone;
            end
            StDone: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            opc_q   <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            level_q <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            level_q <= level_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    // Moore outputs decoded from the state.
    always_comb begin
        op_ready   = (state_q == StIdle);
        rsp_valid  = (state_q == StDone);
        st_pop     = (state_q == StPopA) || (state_q == StPopB);
        st_push    = (state_q == StPush1) || (state_q == StPush2);
        st_data_in = din_q;
        rsp_data   = rdata_q;
        rsp_err    = rerr_q;
        level      = level_q;
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench: sequencer plus a behavioural stack, hand-computed expectations.
module tb_stack_op_sequencer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_imm;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             st_push;
    logic             st_pop;
    logic [WIDTH-1:0] st_data_in;
    logic [WIDTH-1:0] st_data_out;
    logic [LVL_W-1:0] level;

    int checks;
    int errors;
    int push_cnt;
    int pop_cnt;

    stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_imm     (op_imm),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .st_push    (st_push),
        .st_pop     (st_pop),
        .st_data_in (st_data_in),
        .st_data_out(st_data_out),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack: read data appears the cycle after a pop strobe.
    logic [WIDTH-1:0] mem [DEPTH];
    int sp;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp          <= 0;
            st_data_out <= '0;
        end else if (st_push && sp < int'(DEPTH)) begin
            mem[sp] <= st_data_in;
            sp      <= sp + 1;
        end else if (st_pop && sp > 0) begin
            st_data_out <= mem[sp-1];
            sp          <= sp - 1;
        end
    end

    initial begin
        push_cnt = 0;
        pop_cnt  = 0;
    end
    always @(posedge clk) begin
        if (st_push) push_cnt <= push_cnt + 1;
        if (st_pop)  pop_cnt  <= pop_cnt + 1;
    end

    task automatic apply_reset();
        rst       = 1'b0;
        op_valid  = 1'b0;
        op_code   = 3'd0;
        op_imm    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Issue one instruction; latency counts edges from accept (inclusive) to rsp_valid.
    task automatic do_op(input logic [2:0] code, input logic [WIDTH-1:0] imm,
                         output logic [WIDTH-1:0] data, output logic err,
                         output int lat, output int dpush, output int dpop);
        int p0, q0;
        @(negedge clk);
        p0       = push_cnt;
        q0       = pop_cnt;
        op_valid = 1'b1;
        op_code  = code;
        op_imm   = imm;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        data  = rsp_data;
        err   = rsp_err;
        @(posedge clk);
        #1;
        dpush = push_cnt - p0;
        dpop  = pop_cnt - q0;
    endtask

    // Run one op and compare all its observable results against expectations.
    task automatic run_chk(input string name, input logic [2:0] code, input logic [WIDTH-1:0] imm,
                           input logic [WIDTH-1:0] exp_data, input logic exp_err,
                           input int exp_lat, input int exp_lvl, input int exp_push, input int exp_pop);
        logic [WIDTH-1:0] d;
        logic e;
        int lat, dp, dq;
        do_op(code, imm, d, e, lat, dp, dq);
        checks++;
        if (d !== exp_data || e !== exp_err) begin
            errors++;
            $display("FAIL %s rsp: data=%h err=%b expected data=%h err=%b", name, d, e, exp_data, exp_err);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (int'(level) !== exp_lvl) begin
            errors++;
            $display("FAIL %s level: got %0d expected %0d", name, level, exp_lvl);
        end
        checks++;
        if (dp !== exp_push || dq !== exp_pop) begin
            errors++;
            $display("FAIL %s strobes: push=%0d pop=%0d expected push=%0d pop=%0d",
                     name, dp, dq, exp_push, exp_pop);
        end
        checks++;
        if (op_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s return to idle: op_ready=%b rsp_valid=%b expected 1/0",
                     name, op_ready, rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({st_push, st_pop, st_data_in, rsp_valid, rsp_data, rsp_err, level} !== '0) begin
            errors++;
            $display("FAIL reset outputs: push=%b pop=%b din=%h rv=%b rd=%h re=%b lvl=%0d expected all 0",
                     st_push, st_pop, st_data_in, rsp_valid, rsp_data, rsp_err, level);
        end
        apply_reset();
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset op_ready: got %b expected 1", op_ready);
        end
    endtask

    task automatic test_push_fill();
        run_chk("push_0a", 3'd1, 8'h0A, 8'h0A, 1'b0, 2, 1, 1, 0);
        run_chk("push_0b", 3'd1, 8'h0B, 8'h0B, 1'b0, 2, 2, 1, 0);
        run_chk("push_0c", 3'd1, 8'h0C, 8'h0C, 1'b0, 2, 3, 1, 0);
        run_chk("push_full", 3'd1, 8'h0D, 8'h00, 1'b1, 1, 3, 0, 0);
    endtask

    task automatic test_add();
        run_chk("add", 3'd3, 8'h00, 8'h17, 1'b0, 6, 2, 1, 2);
        run_chk("pop_17", 3'd2, 8'h00, 8'h17, 1'b0, 3, 1, 0, 1);
        run_chk("pop_0a", 3'd2, 8'h00, 8'h0A, 1'b0, 3, 0, 0, 1);
    endtask

    task automatic test_sub_dup();
        run_chk("push_05", 3'd1, 8'h05, 8'h05, 1'b0, 2, 1, 1, 0);
        run_chk("push_07", 3'd1, 8'h07, 8'h07, 1'b0, 2, 2, 1, 0);
        run_chk("sub_wrap", 3'd4, 8'h00, 8'hFE, 1'b0, 6, 1, 1, 2);
        run_chk("dup", 3'd5, 8'h00, 8'hFE, 1'b0, 5, 2, 2, 1);
        run_chk("pop_dup1", 3'd2, 8'h00, 8'hFE, 1'b0, 3, 1, 0, 1);
        run_chk("pop_dup2", 3'd2, 8'h00, 8'hFE, 1'b0, 3, 0, 0, 1);
    endtask

    task automatic test_swap();
        run_chk("push_11", 3'd1, 8'h11, 8'h11, 1'b0, 2, 1, 1, 0);
        run_chk("push_22", 3'd1, 8'h22, 8'h22, 1'b0, 2, 2, 1, 0);
        run_chk("swap", 3'd6, 8'h00, 8'h11, 1'b0, 7, 2, 2, 2);
        run_chk("pop_sw1", 3'd2, 8'h00, 8'h11, 1'b0, 3, 1, 0, 1);
        run_chk("pop_sw2", 3'd2, 8'h00, 8'h22, 1'b0, 3, 0, 0, 1);
    endtask

    task automatic test_errors();
        apply_reset();
        run_chk("pop_empty", 3'd2, 8'h00, 8'h00, 1'b1, 1, 0, 0, 0);
        run_chk("nop", 3'd0, 8'h5A, 8'h00, 1'b0, 1, 0, 0, 0);
        run_chk("push_01", 3'd1, 8'h01, 8'h01, 1'b0, 2, 1, 1, 0);
        run_chk("add_under", 3'd3, 8'h00, 8'h00, 1'b1, 1, 1, 0, 0);
        run_chk("reserved", 3'd7, 8'h44, 8'h00, 1'b1, 1, 1, 0, 0);
        run_chk("push_02", 3'd1, 8'h02, 8'h02, 1'b0, 2, 2, 1, 0);
        run_chk("push_03", 3'd1, 8'h03, 8'h03, 1'b0, 2, 3, 1, 0);
        run_chk("dup_over", 3'd5, 8'h00, 8'h00, 1'b1, 1, 3, 0, 0);
    endtask

    // Stack holds [1,2,3]; ADD yields 2+3=5 while the consumer stalls.
    task automatic test_back_to_back();
        int n;
        rsp_ready = 1'b0;
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 3'd3;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL bp latency: got %0d expected 6", n);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h05 || rsp_err !== 1'b0 || op_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp hold %0d: rv=%b rd=%h re=%b ordy=%b expected 1/05/0/0",
                         i, rsp_valid, rsp_data, rsp_err, op_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || op_ready !== 1'b1 || level !== LVL_W'(2)) begin
            errors++;
            $display("FAIL bp release: rv=%b ordy=%b lvl=%0d expected 0/1/2", rsp_valid, op_ready, level);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        run_chk("push_a", 3'd1, 8'h0A, 8'h0A, 1'b0, 2, 1, 1, 0);
        run_chk("push_b", 3'd1, 8'h0B, 8'h0B, 1'b0, 2, 2, 1, 0);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 3'd3;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (st_pop !== 1'b1) begin
            errors++;
            $display("FAIL mid POP_B reached: st_pop=%b expected 1", st_pop);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({st_push, st_pop, st_data_in, rsp_valid, rsp_data, rsp_err, level} !== '0) begin
            errors++;
            $display("FAIL mid reset outputs: push=%b pop=%b din=%h rv=%b rd=%h re=%b lvl=%0d expected all 0",
                     st_push, st_pop, st_data_in, rsp_valid, rsp_data, rsp_err, level);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid release op_ready: got %b expected 1", op_ready);
        end
        run_chk("push_33", 3'd1, 8'h33, 8'h33, 1'b0, 2, 1, 1, 0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        op_valid  = 1'b0;
        op_code   = 3'd0;
        op_imm    = '0;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        test_reset();
        test_push_fill();
        test_add();
        test_sub_dup();
        test_swap();
        test_errors();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Micro-sequencer that executes stack-machine instructions against one `stack` instance by driving its push/pop/data_in strobes.
- Accepts one instruction at a time through a valid/ready handshake.
- Returns the result through a valid/ready response and flags operand underflow or overflow without touching the stack.
- Sits between the instruction decoder and the `stack` datapath; shares `rst` with that stack.

Parameters:
- WIDTH, 8, data word width; must equal the stack's WIDTH.
- DEPTH, 3, stack capacity in entries; must equal the stack's DEPTH.
- LVL_W, $clog2(DEPTH+1), width of the occupancy counter (localparam).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  instruction offered.
- op_ready  out  1  high only in IDLE.
- op_code  in  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 DUP, 6 SWAP, 7 reserved (treated as error).
- op_imm  in  WIDTH  immediate for PUSH.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  WIDTH  result value.
- rsp_err  out  1  instruction rejected; the stack is untouched.
- st_push  out  1  one-cycle push strobe to the stack.
- st_pop  out  1  one-cycle pop strobe to the stack.
- st_data_in  out  WIDTH  write data to the stack.
- st_data_out  in  WIDTH  stack read data; valid in the cycle after an st_pop cycle.
- level  out  LVL_W  current stack occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, level=0.
  - st_push=0, st_pop=0, st_data_in=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - op_ready=1 from the first cycle after release.
  - Reset mid-instruction abandons it; no partial strobes complete.
- FSM states: IDLE, POP_A, CAP_A, POP_B, CAP_B, PUSH_1, PUSH_2, DONE.
- st_pop=1 only in POP_A and POP_B; st_push=1 only in PUSH_1 and PUSH_2 (Moore outputs).
- CAP_A latches a<=st_data_out; CAP_B latches b<=st_data_out. a is the original top, b the original second entry.
- Accept: in IDLE with op_valid=1, latch op_code and op_imm, then check preconditions against level:
  - PUSH: level<DEPTH.
  - POP: level>=1.
  - ADD/SUB/SWAP: level>=2.
  - DUP: level>=1 and level<DEPTH.
  - NOP: none.
  - Precondition fail or opcode 7: go to DONE with rsp_err=1, rsp_data=0, no strobes.
- Sequences (sN = rsp_valid rises N edges after the accept edge):
  - NOP: DONE, rsp_data=0, s1.
  - PUSH: PUSH_1 (st_data_in=imm) -> DONE, rsp_data=imm, s2.
  - POP: POP_A -> CAP_A -> DONE, rsp_data=a, s3.
  - ADD: POP_A, CAP_A, POP_B, CAP_B, PUSH_1 (b+a) -> DONE, rsp_data=b+a, s6.
  - SUB: same sequence with b-a, s6.
  - DUP: POP_A, CAP_A, PUSH_1 (a), PUSH_2 (a) -> DONE, rsp_data=a, s5.
  - SWAP: POP_A, CAP_A, POP_B, CAP_B, PUSH_1 (a), PUSH_2 (b) -> DONE, rsp_data=b, s7.
- Arithmetic is modulo 2^WIDTH; carry and borrow are discarded.
- level: +1 on each st_push cycle, -1 on each st_pop cycle; never leaves 0..DEPTH.
- DONE:
  - rsp_valid=1; rsp_data and rsp_err stay stable until rsp_valid&&rsp_ready.
  - Then return to IDLE and clear rsp_valid; op_ready=0 throughout.
- Net level change per instruction: PUSH +1, POP -1, ADD/SUB -1, DUP +1, SWAP 0, NOP/error 0.
- st_data_in holds its last driven value outside push cycles.
- The stack's own full/empty outputs are not used; level is authoritative.

Decomposition:
- Package stack_pkg holds:
  - opcode constants OP_NOP..OP_SWAP (3-bit);
  - the FSM state encoding;
  - the response error code.
- No sub-module. The ALU is a single add/subtract expression inside the sequencer.
- The stack is instantiated beside this block at the top level, not inside it.

Test Plan (WIDTH=8, DEPTH=3, bench instantiates stack + sequencer):
1. Reset, then PUSH 0x0A, 0x0B, 0x0C -> each rsp_err=0, rsp_data=imm, latency 2, level 1/2/3. Then PUSH 0x0D -> rsp_err=1, no st_push pulse, level stays 3.
2. With [0x0A,0x0B,0x0C(top)], ADD -> pops 0x0C then 0x0B, pushes 0x17, rsp_data=0x17 after 6 edges, level=2. Then POP -> 0x17, POP -> 0x0A.
3. PUSH 0x05, PUSH 0x07, SUB -> rsp_data=0xFE (wrap), level=1. Then DUP -> rsp_data=0xFE, level=2. Two POPs both return 0xFE.
4. PUSH 0x11, PUSH 0x22, SWAP -> rsp_data=0x11, level=2. POP -> 0x11, then POP -> 0x22.
5. Underflow/overflow errors:
   - From reset: POP -> rsp_err=1 after 1 edge, no st_pop.
   - PUSH 0x01, then ADD -> rsp_err=1, level=1.
   - Fill to 3, then DUP -> rsp_err=1, level=3.
6. Backpressure and mid-op reset:
   - ADD with rsp_ready=0 for 3 cycles -> rsp_valid, rsp_data, rsp_err stable and op_ready=0.
   - A separate ADD with rst pulsed low during POP_B -> all outputs 0, level=0 immediately. After release op_ready=1 and PUSH 0x33 succeeds with level=1.
